// File: rtl/power_budget_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : power_budget_scheduler
// Brief    : Shares one chip power budget between N hash cores through a
//            round-robin level request/grant handshake. The budget is derated
//            or shed from the thermal model's temperature and throttle flag,
//            and over-budget grants are revoked one per cycle, highest index
//            first.
// Revision : 1.0 - initial release
// ============================================================================
module power_budget_scheduler #(
  parameter int          N_CORES     = 4,
  parameter logic [15:0] SLICE_MW    = 16'd400,
  parameter logic [7:0]  COOL_CYCLES = 8'd16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_CORES-1:0] req,
  output logic [N_CORES-1:0] grant,
  input  logic [7:0]         temperature,
  input  logic               throttle_request,
  input  logic [15:0]        power_limit,
  input  logic [7:0]         temp_warning,
  input  logic [7:0]         temp_critical,
  output logic [15:0]        budget_mw,
  output logic [15:0]        allocated_mw,
  output logic [1:0]         sched_state,
  output logic [7:0]         revoke_count
);

  // Index, population-count and allocation-sum widths. The allocation sum is
  // kept wide enough that any result above 16'hFFFF compares as over budget.
  localparam int c_ptr_w = $clog2(N_CORES);
  localparam int c_cnt_w = $clog2(N_CORES + 1);
  localparam int c_sum_w = 17 + c_cnt_w;

  localparam logic [1:0] c_st_normal   = 2'd0;
  localparam logic [1:0] c_st_derated  = 2'd1;
  localparam logic [1:0] c_st_shed     = 2'd2;
  localparam logic [1:0] c_st_cooldown = 2'd3;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [c_cnt_w-1:0] popcount(input logic [N_CORES-1:0] v);
    logic [c_cnt_w-1:0] n;
    n = '0;
    for (int i = 0; i < N_CORES; i++) begin
      n = n + c_cnt_w'(v[i]);
    end
    return n;
  endfunction

  // Power drawn by n granted cores, without truncation.
  function automatic logic [c_sum_w-1:0] mw_of(input logic [c_cnt_w-1:0] n);
    return c_sum_w'(SLICE_MW) * c_sum_w'(n);
  endfunction

  // Index of the highest set bit (callers only use it when v is non-zero).
  function automatic logic [c_ptr_w-1:0] highest(input logic [N_CORES-1:0] v);
    logic [c_ptr_w-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (v[i]) idx = c_ptr_w'(i);
    end
    return idx;
  endfunction

  // First set bit of v at or after ptr, wrapping; MSB of the result flags
  // that one was found. Walking downward lets the closest candidate win.
  function automatic logic [c_ptr_w:0] rr_pick(input logic [N_CORES-1:0] v,
                                               input logic [c_ptr_w-1:0] ptr);
    logic [c_ptr_w:0] res;
    logic [c_ptr_w:0] idx;
    res = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (c_ptr_w + 1)'(k);
      if (idx >= (c_ptr_w + 1)'(N_CORES)) idx = idx - (c_ptr_w + 1)'(N_CORES);
      if (v[idx[c_ptr_w-1:0]]) res = {1'b1, idx[c_ptr_w-1:0]};
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         state_q,  state_d;
  logic [7:0]         cool_q,   cool_d;
  logic [15:0]        budget_q, budget_d;
  logic [N_CORES-1:0] grant_q,  grant_d;
  logic [c_ptr_w-1:0] ptr_q,    ptr_d;
  logic [7:0]         revoke_q, revoke_d;
  logic [15:0]        alloc_q,  alloc_d;

  logic               w_warm;
  logic               w_hot;
  logic               w_enter_shed;
  logic [N_CORES-1:0] w_keep;
  logic [N_CORES-1:0] w_eligible;
  logic [c_sum_w-1:0] w_alloc_post;
  logic               w_over;
  logic               w_fit;
  logic [c_ptr_w:0]   w_pick_res;
  logic               w_pick_found;
  logic [c_ptr_w-1:0] w_pick;
  logic [c_ptr_w-1:0] w_hi;
  logic [c_cnt_w-1:0] w_rev_add;
  logic [8:0]         w_rev_sum;

  assign w_warm = (temperature >= temp_warning) || throttle_request;
  assign w_hot  = (temperature >= temp_critical);

  // Thermal state machine and cooldown hold-off counter.
  always_comb begin
    state_d = state_q;
    cool_d  = '0;
    if (w_hot) begin
      state_d = c_st_shed;
    end else begin
      case (state_q)
        c_st_normal: begin
          if (w_warm) state_d = c_st_derated;
        end
        c_st_derated: begin
          if (!w_warm) begin
            state_d = c_st_cooldown;
            cool_d  = COOL_CYCLES;
          end
        end
        c_st_shed: begin
          // Throttle alone does not hold SHED; only temperature does.
          if (temperature < temp_warning) begin
            state_d = c_st_cooldown;
            cool_d  = COOL_CYCLES;
          end
        end
        default: begin
          if (w_warm) begin
            state_d = c_st_derated;
          end else if (cool_q <= 8'd1) begin
            state_d = c_st_normal;
          end else begin
            cool_d = cool_q - 8'd1;
          end
        end
      endcase
    end
  end

  // Budget that applies to the state being entered on this edge.
  always_comb begin
    case (state_d)
      c_st_normal: budget_d = power_limit;
      c_st_shed:   budget_d = 16'd0;
      default:     budget_d = power_limit >> 1;
    endcase
  end

  // Allocation bookkeeping against the next budget.
  assign w_enter_shed = (state_d == c_st_shed) && (state_q != c_st_shed);
  assign w_keep       = grant_q & req;
  assign w_eligible   = req & ~grant_q;
  assign w_alloc_post = mw_of(popcount(w_keep));
  assign w_over       = w_alloc_post > c_sum_w'(budget_d);
  assign w_fit        = (w_alloc_post + c_sum_w'(SLICE_MW)) <= c_sum_w'(budget_d);
  assign w_pick_res   = rr_pick(w_eligible, ptr_q);
  assign w_pick_found = w_pick_res[c_ptr_w];
  assign w_pick       = w_pick_res[c_ptr_w-1:0];
  assign w_hi         = highest(w_keep);
  assign w_rev_add    = w_enter_shed ? popcount(grant_q) : c_cnt_w'(w_over);
  assign w_rev_sum    = {1'b0, revoke_q} + 9'(w_rev_add);

  // Grant update: shed clears everything, over-budget revokes one grant,
  // otherwise releases apply and at most one new round-robin grant is issued.
  always_comb begin
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    revoke_d = w_rev_sum[8] ? 8'hFF : w_rev_sum[7:0];
    if (w_enter_shed) begin
      grant_d = '0;
    end else if (w_over) begin
      grant_d       = w_keep;
      grant_d[w_hi] = 1'b0;
    end else begin
      grant_d = w_keep;
      if (w_pick_found && w_fit) begin
        grant_d[w_pick] = 1'b1;
        ptr_d = (w_pick == c_ptr_w'(N_CORES - 1)) ? '0 : w_pick + c_ptr_w'(1);
      end
    end
  end

  // Registered allocation mirrors the next grant vector.
  always_comb begin
    alloc_d = 16'(SLICE_MW * 16'(popcount(grant_d)));
  end

  // All scheduler state, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= c_st_normal;
      cool_q   <= '0;
      budget_q <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      revoke_q <= '0;
      alloc_q  <= '0;
    end else begin
      state_q  <= state_d;
      cool_q   <= cool_d;
      budget_q <= budget_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      revoke_q <= revoke_d;
      alloc_q  <= alloc_d;
    end
  end

  assign grant        = grant_q;
  assign budget_mw    = budget_q;
  assign allocated_mw = alloc_q;
  assign sched_state  = state_q;
  assign revoke_count = revoke_q;

endmodule
`default_nettype wire
